mole_arena: RTL and testbench

- Parametrised successor to the whack-a-mole core.
- Runs complete timed games on an N_CELLS grid. Each round, two internal LFSRs place one good mole and one bad mole.
- Scores player hits with reaction-time grading, a combo bonus and a difficulty level. Score saturates.
- Sits between the board I/O (Hit_point, LED outputs) and the score/countdown display.

---
 rtl/mole_arena_if.sv | 29 ++
 rtl/mole_arena.sv | 246 ++++++++++++++++++++++++
 tb/tb_mole_arena.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_arena_if.sv
// Board-side bundle for the mole arena: player inputs in, score/countdown/LED outputs back.
// The board or testbench holds the master end, the game core the slave end.
interface mole_arena_if #(
    parameter int N_CELLS = 16,
    parameter int LFSR_W  = 15,
    parameter int SCORE_W = 10,
    parameter int CD_W    = 5
);
    logic                      game_start;
    logic [2*LFSR_W-1:0]       seed;
    logic [1:0]                level;
    logic [N_CELLS-1:0]        hit_point;
    logic [CD_W-1:0]           countdown;
    logic signed [SCORE_W-1:0] score;
    logic [N_CELLS-1:0]        good_mole;
    logic [N_CELLS-1:0]        bad_mole;
    logic                      game_active;
    logic                      game_done;

    modport master (
        output game_start, seed, level, hit_point,
        input  countdown, score, good_mole, bad_mole, game_active, game_done
    );

    modport slave (
        input  game_start, seed, level, hit_point,
        output countdown, score, good_mole, bad_mole, game_active, game_done
    );
endinterface

// File: rtl/mole_arena.sv
// Timed whack-a-mole game core: two LFSRs place a good and a bad mole each round, and
// edge-detected hits are graded by reaction phase, combo streak and difficulty level.
module mole_arena #(
    parameter int N_CELLS      = 16,
    parameter int LFSR_W       = 15,
    parameter int ROUND_CYCLES = 10,
    parameter int GAME_ROUNDS  = 30,
    parameter int ARM_CYCLES   = 5,
    parameter int GOOD_MAX     = 4,
    parameter int BAD_PENALTY  = 5,
    parameter int COMBO_LEN    = 3,
    parameter int SCORE_W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    mole_arena_if.slave  bus
);
    localparam int ADDR_W    = $clog2(N_CELLS);
    localparam int CD_W      = $clog2(GAME_ROUNDS + 1);
    localparam int PH_W      = $clog2(ROUND_CYCLES + 1);
    localparam int ARM_W     = $clog2(ARM_CYCLES + 1);
    localparam int CB_W      = $clog2(COMBO_LEN + 1);
    localparam int SCORE_MAX = (2 ** (SCORE_W - 1)) - 1;
    localparam int SCORE_MIN = -(2 ** (SCORE_W - 1));

    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(ROUND_CYCLES - 1);
    localparam logic [PH_W-1:0]  FULL_VIS   = PH_W'(ROUND_CYCLES);
    localparam logic [PH_W-1:0]  MIN_VIS    = PH_W'(2);
    localparam logic [ARM_W-1:0] ARM_LAST   = ARM_W'(ARM_CYCLES - 1);
    localparam logic [CB_W-1:0]  COMBO_SAT  = CB_W'(COMBO_LEN);
    localparam logic [CD_W-1:0]  CD_START   = CD_W'(GAME_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ROUND,
        DONE
    } state_t;

    state_t                    state;
    logic [LFSR_W-1:0]         lfsr_g;
    logic [LFSR_W-1:0]         lfsr_b;
    logic [PH_W-1:0]           phase;
    logic [ARM_W-1:0]          arm_cnt;
    logic [CB_W-1:0]           combo;
    logic [N_CELLS-1:0]        hit_prev;
    logic                      round_hit;
    logic                      round_good;
    logic [1:0]                level_q;
    logic [CD_W-1:0]           countdown_q;
    logic signed [SCORE_W-1:0] score_q;
    logic [N_CELLS-1:0]        good_q;
    logic [N_CELLS-1:0]        bad_q;
    logic                      active_q;
    logic                      done_q;

    logic [LFSR_W-1:0]         lfsr_g_nx;
    logic [LFSR_W-1:0]         lfsr_b_nx;
    logic [LFSR_W-1:0]         seed_g;
    logic [LFSR_W-1:0]         seed_b;
    logic [ADDR_W-1:0]         good_addr;
    logic [ADDR_W-1:0]         bad_addr;
    logic [N_CELLS-1:0]        good_place;
    logic [N_CELLS-1:0]        bad_place;
    logic [PH_W-1:0]           vis_full;
    logic [PH_W-1:0]           vis;
    logic [PH_W-1:0]           phase_inc;

    logic [N_CELLS-1:0]        rise;
    logic                      eval_ok;
    logic                      good_hit;
    logic                      bad_hit;
    int                        pts;
    int                        delta;
    int                        sum;
    logic signed [SCORE_W-1:0] score_nx;
    logic [CB_W-1:0]           combo_inc;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[LFSR_W-1] ^ q[LFSR_W-2]};
    endfunction

    // Moles are placed from the stepped LFSR values, so the displayed cells always match
    // the LFSR contents held for the rest of the round.
    always_comb begin
        lfsr_g_nx = lfsr_step(lfsr_g);
        lfsr_b_nx = lfsr_step(lfsr_b);
        good_addr = lfsr_g_nx[ADDR_W-1:0];
        bad_addr  = lfsr_b_nx[ADDR_W-1:0];
        if (bad_addr == good_addr) begin
            bad_addr = bad_addr + ADDR_W'(1);
        end
        good_place = N_CELLS'(1) << good_addr;
        bad_place  = N_CELLS'(1) << bad_addr;

        seed_g = bus.seed[2*LFSR_W-1:LFSR_W];
        seed_b = bus.seed[LFSR_W-1:0];
        if (seed_g == '0) begin
            seed_g = LFSR_W'(1);
        end
        if (seed_b == '0) begin
            seed_b = LFSR_W'(1);
        end

        vis_full  = FULL_VIS >> level_q;
        vis       = (vis_full < MIN_VIS) ? MIN_VIS : vis_full;
        phase_inc = phase + PH_W'(1);
    end

    // Only the first hit on a visible mole per round is scored; bad beats good.
    always_comb begin
        rise     = bus.hit_point & ~hit_prev;
        eval_ok  = (state == ROUND) && (|good_q) && !round_hit;
        bad_hit  = eval_ok && (|(rise & bad_q));
        good_hit = eval_ok && !bad_hit && (|(rise & good_q));

        pts = GOOD_MAX - int'(phase);
        if (pts < 1) begin
            pts = 1;
        end
        if (int'(combo) >= COMBO_LEN - 1) begin
            pts = pts + 1;
        end
        delta = bad_hit ? -BAD_PENALTY : pts;

        sum = int'(score_q) + delta;
        if (sum > SCORE_MAX) begin
            sum = SCORE_MAX;
        end else if (sum < SCORE_MIN) begin
            sum = SCORE_MIN;
        end
        score_nx = SCORE_W'(sum);

        combo_inc = (combo == COMBO_SAT) ? combo : combo + CB_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr_g      <= LFSR_W'(1);
            lfsr_b      <= LFSR_W'(1);
            phase       <= '0;
            arm_cnt     <= '0;
            combo       <= '0;
            hit_prev    <= '0;
            round_hit   <= 1'b0;
            round_good  <= 1'b0;
            level_q     <= '0;
            countdown_q <= '0;
            score_q     <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            hit_prev <= bus.hit_point;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.game_start) begin
                        state       <= ARM;
                        lfsr_g      <= seed_g;
                        lfsr_b      <= seed_b;
                        countdown_q <= CD_START;
                        score_q     <= '0;
                        combo       <= '0;
                        level_q     <= bus.level;
                        arm_cnt     <= '0;
                        phase       <= '0;
                        active_q    <= 1'b1;
                    end
                end
                ARM: begin
                    if (arm_cnt == ARM_LAST) begin
                        state      <= ROUND;
                        phase      <= '0;
                        lfsr_g     <= lfsr_g_nx;
                        lfsr_b     <= lfsr_b_nx;
                        good_q     <= good_place;
                        bad_q      <= bad_place;
                        round_hit  <= 1'b0;
                        round_good <= 1'b0;
                    end else begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end
                end
                ROUND: begin
                    if (good_hit || bad_hit) begin
                        score_q   <= score_nx;
                        good_q    <= '0;
                        bad_q     <= '0;
                        round_hit <= 1'b1;
                    end

                    // A round that closes without a good hit breaks the streak.
                    if (bad_hit) begin
                        combo <= '0;
                    end else if (good_hit) begin
                        combo      <= combo_inc;
                        round_good <= 1'b1;
                    end else if ((phase == LAST_PHASE) && !round_good) begin
                        combo <= '0;
                    end

                    if (phase == LAST_PHASE) begin
                        countdown_q <= countdown_q - CD_W'(1);
                        if (countdown_q == CD_W'(1)) begin
                            state    <= DONE;
                            good_q   <= '0;
                            bad_q    <= '0;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            phase      <= '0;
                            lfsr_g     <= lfsr_g_nx;
                            lfsr_b     <= lfsr_b_nx;
                            good_q     <= good_place;
                            bad_q      <= bad_place;
                            round_hit  <= 1'b0;
                            round_good <= 1'b0;
                        end
                    end else begin
                        phase <= phase_inc;
                        if (phase_inc == vis) begin
                            good_q <= '0;
                            bad_q  <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.countdown   = countdown_q;
    assign bus.score       = score_q;
    assign bus.good_mole   = good_q;
    assign bus.bad_mole    = bad_q;
    assign bus.game_active = active_q;
    assign bus.game_done   = done_q;
endmodule

// File: tb/tb_mole_arena.sv
// Directed bench for mole_arena: a round-by-round vector table plus hand-written
// sequences for visibility, hold/edge detection, mid-game reset and saturation.
module tb_mole_arena;
    localparam int RC = 10;
    localparam int ARM_CYCLES = 5;

    localparam int K_NONE  = 0;
    localparam int K_GOOD  = 1;
    localparam int K_BAD   = 2;
    localparam int K_BOTH  = 3;
    localparam int K_EMPTY = 4;

    typedef struct {
        int hit_phase;
        int kind;
        int exp_score;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [14:0] mg;
    logic [14:0] mb;
    int   phase_m;
    int   round_m;
    vec_t vecs [13];

    mole_arena_if #(.N_CELLS(16), .LFSR_W(15), .SCORE_W(10), .CD_W(5)) bus ();
    mole_arena_if #(.N_CELLS(4),  .LFSR_W(15), .SCORE_W(4),  .CD_W(5)) bus4 ();

    mole_arena dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mole_arena #(.N_CELLS(4), .SCORE_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [14:0] lfsr_adv(input logic [14:0] q);
        logic fb;
        fb = q[14] ^ q[13];
        return (q << 1) | 15'(fb);
    endfunction

    function automatic int good_cell(input logic [14:0] g, input int n);
        return int'(g) % n;
    endfunction

    function automatic int bad_cell(input logic [14:0] g, input logic [14:0] b, input int n);
        int ga;
        int ba;
        ga = int'(g) % n;
        ba = int'(b) % n;
        if (ba == ga) ba = (ba + 1) % n;
        return ba;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (phase_m == RC - 1) begin
            phase_m = 0;
            round_m++;
            mg = lfsr_adv(mg);
            mb = lfsr_adv(mb);
        end else begin
            phase_m++;
        end
    endtask

    task automatic checkMoles();
        logic [15:0] eg;
        logic [15:0] eb;
        eg = 16'(1) << good_cell(mg, 16);
        eb = 16'(1) << bad_cell(mg, mb, 16);
        checkOutput("good_mole", bus.good_mole, eg);
        checkOutput("bad_mole", bus.bad_mole, eb);
    endtask

    task automatic startGame(input logic [29:0] sd, input logic [1:0] lvl);
        bus.seed = sd;
        bus.level = lvl;
        bus.game_start = 1'b1;
        @(negedge clk);
        bus.game_start = 1'b0;
        checkOutput("active_rise", bus.game_active, 1);
        mg = (sd[29:15] == 15'd0) ? 15'd1 : sd[29:15];
        mb = (sd[14:0] == 15'd0) ? 15'd1 : sd[14:0];
        repeat (ARM_CYCLES - 1) @(negedge clk);
        checkOutput("no_mole_in_arm", bus.good_mole | bus.bad_mole, 0);
        @(negedge clk);
        mg = lfsr_adv(mg);
        mb = lfsr_adv(mb);
        phase_m = 0;
        round_m = 1;
        checkOutput("countdown_start", bus.countdown, 30);
    endtask

    // One vector covers one full round, starting and ending at a phase-0 negedge.
    task automatic applyStimulus(input vec_t v);
        int gc;
        int bc;
        int ec;
        logic [15:0] hp;
        checkMoles();
        gc = good_cell(mg, 16);
        bc = bad_cell(mg, mb, 16);
        ec = 0;
        while (ec == gc || ec == bc) ec++;
        for (int p = 0; p < RC; p++) begin
            hp = '0;
            if (p == v.hit_phase) begin
                case (v.kind)
                    K_GOOD:  hp = 16'(1) << gc;
                    K_BAD:   hp = 16'(1) << bc;
                    K_BOTH:  hp = (16'(1) << gc) | (16'(1) << bc);
                    K_EMPTY: hp = 16'(1) << ec;
                    default: hp = '0;
                endcase
            end else if (v.kind >= K_GOOD && v.kind <= K_BOTH && p == v.hit_phase + 2) begin
                hp = 16'(1) << gc;
            end
            bus.hit_point = hp;
            if (v.kind >= K_GOOD && v.kind <= K_BOTH && p == v.hit_phase + 1) begin
                checkOutput("score_after_hit", bus.score, v.exp_score);
                checkOutput("moles_cleared", bus.good_mole | bus.bad_mole, 0);
            end
            tick();
        end
        bus.hit_point = '0;
        checkOutput("score_round_end", bus.score, v.exp_score);
    endtask

    initial begin
        logic saw_done;
        int bc4;
        errors = 0;
        checks = 0;
        phase_m = 0;
        round_m = 0;
        mg = 15'd1;
        mb = 15'd1;
        bus.game_start = 1'b0;
        bus.seed = '0;
        bus.level = '0;
        bus.hit_point = '0;
        bus4.game_start = 1'b0;
        bus4.seed = '0;
        bus4.level = '0;
        bus4.hit_point = '0;

        vecs[0]  = '{0, K_GOOD, 4};
        vecs[1]  = '{1, K_GOOD, 7};
        vecs[2]  = '{2, K_GOOD, 10};
        vecs[3]  = '{5, K_GOOD, 12};
        vecs[4]  = '{3, K_BAD, 7};
        vecs[5]  = '{0, K_GOOD, 11};
        vecs[6]  = '{1, K_BOTH, 6};
        vecs[7]  = '{-1, K_NONE, 6};
        vecs[8]  = '{8, K_GOOD, 7};
        vecs[9]  = '{0, K_GOOD, 11};
        vecs[10] = '{2, K_EMPTY, 11};
        vecs[11] = '{0, K_GOOD, 15};
        vecs[12] = '{3, K_GOOD, 16};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_score", bus.score, 0);
        checkOutput("rst_countdown", bus.countdown, 0);
        checkOutput("rst_moles", bus.good_mole | bus.bad_mole, 0);
        checkOutput("rst_active", bus.game_active, 0);
        checkOutput("rst_done", bus.game_done, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] game 1: no hits, seed 123456789");
        startGame(30'd123456789, 2'd0);
        for (int r = 1; r <= 30; r++) begin
            checkOutput("countdown", bus.countdown, 31 - r);
            checkMoles();
            repeat (RC - 1) tick();
            if (r == 30) checkOutput("done_not_early", bus.game_done, 0);
            tick();
        end
        checkOutput("done_pulse", bus.game_done, 1);
        checkOutput("done_countdown", bus.countdown, 0);
        checkOutput("done_active", bus.game_active, 0);
        checkOutput("done_moles", bus.good_mole | bus.bad_mole, 0);
        checkOutput("done_score", bus.score, 0);
        tick();
        checkOutput("done_one_cycle", bus.game_done, 0);

        $display("[TB] game 2: scoring vector table, level 0");
        startGame(30'h2AB31C4D, 2'd0);
        for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);
        for (int r = 14; r <= 30; r++) repeat (RC) tick();
        checkOutput("done2_pulse", bus.game_done, 1);
        tick();
        tick();
        checkOutput("idle_score_hold", bus.score, 16);
        checkOutput("idle_countdown_hold", bus.countdown, 0);

        $display("[TB] game 3: level 3, seed 0");
        startGame(30'd0, 2'd3);
        for (int r = 1; r <= 30; r++) begin
            for (int p = 0; p < RC; p++) begin
                if (p == 0) checkMoles();
                if (r == 1 && p == 1) checkOutput("vis_lvl3_on", (bus.good_mole != 0), 1);
                if (r == 1 && p == 2) begin
                    checkOutput("vis_lvl3_off", bus.good_mole | bus.bad_mole, 0);
                    bus.hit_point = 16'(1) << good_cell(mg, 16);
                end
                if (r == 1 && p == 3) begin
                    bus.hit_point = '0;
                    checkOutput("late_hit_ignored", bus.score, 0);
                end
                if (r == 3 && p == 8) bus.hit_point = 16'(1) << good_cell(lfsr_adv(mg), 16);
                if (r == 4 && p == 2) begin
                    bus.hit_point = '0;
                    checkOutput("held_no_rise", bus.score, 0);
                end
                if (r == 5 && p == 0) bus.hit_point = 16'(1) << good_cell(mg, 16);
                if (r == 5 && p == 1) checkOutput("hit_lvl3", bus.score, 4);
                if (r == 5 && p == 4) begin
                    bus.hit_point = '0;
                    checkOutput("held_once", bus.score, 4);
                end
                tick();
            end
        end
        checkOutput("done3_pulse", bus.game_done, 1);
        checkOutput("done3_score", bus.score, 4);
        tick();

        $display("[TB] game 4: reset asserted in round 12");
        startGame(30'd123456789, 2'd0);
        bus.hit_point = 16'(1) << good_cell(mg, 16);
        tick();
        bus.hit_point = '0;
        checkOutput("g4_first_hit", bus.score, 4);
        repeat (11 * RC + 3 - 1) tick();
        checkOutput("g4_countdown_r12", bus.countdown, 19);
        rst = 1'b1;
        #1;
        checkOutput("set_score", bus.score, 0);
        checkOutput("set_countdown", bus.countdown, 0);
        checkOutput("set_moles", bus.good_mole | bus.bad_mole, 0);
        checkOutput("set_active", bus.game_active, 0);
        checkOutput("set_done", bus.game_done, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.game_done) saw_done = 1'b1;
        end
        checkOutput("no_done_after_set", saw_done, 0);
        checkOutput("idle_after_set", bus.game_active, 0);

        $display("[TB] small arena: score saturation");
        bus4.seed = 30'h00010003;
        bus4.level = 2'd0;
        bus4.game_start = 1'b1;
        @(negedge clk);
        bus4.game_start = 1'b0;
        mg = 15'd2;
        mb = 15'd3;
        repeat (ARM_CYCLES) @(negedge clk);
        mg = lfsr_adv(mg);
        mb = lfsr_adv(mb);
        phase_m = 0;
        round_m = 1;
        for (int k = 0; k < 3; k++) begin
            bc4 = bad_cell(mg, mb, 4);
            checkOutput("small_bad_mole", bus4.bad_mole, 4'(1) << bc4);
            bus4.hit_point = 4'(1) << bc4;
            tick();
            bus4.hit_point = '0;
            checkOutput("small_score", bus4.score, (k == 0) ? -5 : -8);
            repeat (RC - 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
